// File: rtl/fifo_read_drainer_if.sv
// Handshake bundle for fifo_read_drainer: FIFO read port plus the
// downstream valid/ready stream. The drainer connects as master, the
// FIFO/sink environment as slave.
interface fifo_read_drainer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: read-clock-domain consumer for an asynchronous FIFO.
// Pops words while enabled, absorbs the FIFO's one-cycle read latency in a
// 3-entry circular buffer and streams words out on valid/ready.
// fifo_rd_en is a function of registered state, i_enable and fifo_empty
// only, so there is no combinational path from out_ready to the FIFO.
// Optional feature: define FIFO_READER_SEQ_CHECK_EN to enable the
// incrementing-sequence checker driving o_seq_error (tied 0 otherwise).
//
// state | meaning
// IDLE  | no reads, buffer empty
// RUN   | reads issued while credit (occ + inflight < 3) allows
// DRAIN | enable dropped; no new reads, buffer and in-flight word flushed
module fifo_read_drainer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_read_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  fifo_read_drainer_if.master  bus,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_word_count,
  output logic                 o_seq_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_busy;

  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [3];
  logic [CNT_WIDTH-1:0]  r_word_count;

  logic [2:0]            w_pending;
  logic                  w_credit;
  logic                  w_rd_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts both buffered words and the word still in flight.
  assign w_pending   = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_credit    = (w_pending < 3'd3);
  assign w_rd_en     = (r_state == RUN) && i_enable && !bus.fifo_empty && w_credit;
  assign w_out_valid = (r_occ != 2'd0);
  assign w_push      = r_inflight;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_mem[r_rptr];
  assign o_busy         = w_busy;
  assign o_word_count   = r_word_count;

  // State register.
  always_ff @(posedge i_read_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable) w_state_nxt = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (!i_enable) begin
          if (w_out_valid || r_inflight) w_state_nxt = DRAIN;
          else                           w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (i_enable)                          w_state_nxt = RUN;
        else if (!w_out_valid && !r_inflight)  w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Read tracking, circular buffer and delivered-word counter.
  always_ff @(posedge i_read_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inflight   <= 1'b0;
      r_occ        <= 2'd0;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_word_count <= '0;
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) begin
        r_mem[r_wptr] <= bus.fifo_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr       <= ptr_inc(r_rptr);
        r_word_count <= r_word_count + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_READER_SEQ_CHECK_EN
  logic                  r_have_base;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_seq_error;

  assign o_seq_error = r_seq_error;

  // Compare each accepted word against the previous one plus one; sticky.
  always_ff @(posedge i_read_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_have_base <= 1'b0;
      r_prev      <= '0;
      r_seq_error <= 1'b0;
    end else if (w_pop) begin
      if (r_have_base && (bus.out_data != (r_prev + DATA_WIDTH'(1)))) begin
        r_seq_error <= 1'b1;
      end
      r_prev      <= bus.out_data;
      r_have_base <= 1'b1;
    end
  end
`else
  assign o_seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Bench for fifo_read_drainer: a FIFO read-port model with one-cycle read
// latency feeds the DUT; loaded words are queued as expectations and a
// monitor compares every accepted word in order.
module tb_fifo_read_drainer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        busy;
  logic [15:0] word_count;
  logic        seq_error;

  fifo_read_drainer_if #(.DATA_WIDTH(16)) bus ();

  fifo_read_drainer #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .i_read_clk   (clk),
    .i_reset_n    (reset_n),
    .i_enable     (enable),
    .bus          (bus),
    .o_busy       (busy),
    .o_word_count (word_count),
    .o_seq_error  (seq_error)
  );

`ifdef FIFO_READER_SEQ_CHECK_EN
  localparam logic EXP_SEQ_ERR = 1'b1;
`else
  localparam logic EXP_SEQ_ERR = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] fifo_mem [$];
  logic [15:0] sb [$];
  int          rd_idx   = 0;
  int          rd_count = 0;

  int empty_viol = 0;
  int hold_viol  = 0;
  int idle_viol  = 0;
  int rate_viol  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO read-port model: data appears the cycle after a pop strobe.
  always @(posedge clk) begin
    if (!reset_n) begin
      rd_idx         <= fifo_mem.size();
      bus.fifo_empty <= 1'b1;
      bus.fifo_data  <= 16'h0000;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_data  <= fifo_mem[rd_idx];
      rd_idx         <= rd_idx + 1;
      rd_count       <= rd_count + 1;
      bus.fifo_empty <= ((rd_idx + 1) == fifo_mem.size());
    end else begin
      bus.fifo_empty <= (rd_idx == fifo_mem.size());
    end
  end

  // Monitor: in-order scoreboard compare on each accepted word.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [15:0] exp_w;
    prev_stall = 1'b0;
    prev_data  = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.fifo_rd_en && bus.fifo_empty) empty_viol++;
        if (prev_stall && (bus.out_data !== prev_data)) hold_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.out_data);
          end else begin
            exp_w = sb.pop_front();
            check("stream_word", {16'h0, bus.out_data}, {16'h0, exp_w});
          end
        end
      end
    end
  end

  task automatic load(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem.push_back(first + 16'(i));
      sb.push_back(first + 16'(i));
    end
  endtask

  task automatic wait_drained(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.out_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, (k < budget)}, 32'h1);
  endtask

  initial begin
    int k;
    int r0;
    reset_n       = 1'b0;
    enable        = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rd_en",      {31'h0, bus.fifo_rd_en}, 32'h0);
    check("rst_out_valid",  {31'h0, bus.out_valid},  32'h0);
    check("rst_out_data",   {16'h0, bus.out_data},   32'h0);
    check("rst_busy",       {31'h0, busy},           32'h0);
    check("rst_word_count", {16'h0, word_count},     32'h0);
    check("rst_seq_error",  {31'h0, seq_error},      32'h0);
    reset_n = 1'b1;

    // Streaming 0x0000..0x0009
    load(16'h0000, 10);
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.fifo_rd_en) idle_viol++;
    end
    enable = 1'b1;
    @(negedge clk);
    check("run_busy",        {31'h0, busy},           32'h1);
    check("first_rd_c_plus1",{31'h0, bus.fifo_rd_en}, 32'h1);
    @(negedge clk);
    check("latency_n_plus1", {31'h0, bus.out_valid},  32'h0);
    @(negedge clk);
    check("latency_n_plus2", {31'h0, bus.out_valid},  32'h1);
    check("first_word",      {16'h0, bus.out_data},   32'h0);
    repeat (9) begin
      @(negedge clk);
      if (!bus.out_valid) rate_viol++;
    end
    @(negedge clk);
    check("stream_done_valid", {31'h0, bus.out_valid}, 32'h0);
    check("stream_count",      {16'h0, word_count},    32'd10);
    check("stream_seq_error",  {31'h0, seq_error},     32'h0);

    // Backpressure
    bus.out_ready = 1'b0;
    r0 = rd_count;
    load(16'h000A, 8);
    repeat (8) @(negedge clk);
    check("bp_reads",     rd_count - r0,           32'd3);
    check("bp_rd_en_low", {31'h0, bus.fifo_rd_en}, 32'h0);
    check("bp_valid",     {31'h0, bus.out_valid},  32'h1);
    check("bp_head",      {16'h0, bus.out_data},   32'h000A);
    repeat (3) @(negedge clk);
    check("bp_head_held", {16'h0, bus.out_data},   32'h000A);
    bus.out_ready = 1'b1;
    wait_drained("bp_drain_timeout", 60);
    check("bp_count", {16'h0, word_count}, 32'd18);

    // Empty boundary: single word
    r0 = rd_count;
    load(16'h0012, 1);
    repeat (8) @(negedge clk);
    check("one_word_reads", rd_count - r0,          32'd1);
    check("one_word_valid", {31'h0, bus.out_valid}, 32'h0);
    check("one_word_count", {16'h0, word_count},    32'd19);

    // Drain with occ=2, inflight=1
    bus.out_ready = 1'b0;
    r0 = rd_count;
    load(16'h0013, 5);
    repeat (4) @(negedge clk);
    check("drain_pre_reads", rd_count - r0, 32'd3);
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_busy",  {31'h0, busy},           32'h1);
    check("drain_no_rd", {31'h0, bus.fifo_rd_en}, 32'h0);
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle_timeout", {31'h0, (k < 20)},    32'h1);
    check("drain_reads",        rd_count - r0,        32'd3);
    check("drain_count",        {16'h0, word_count},  32'd22);
    check("drain_valid",        {31'h0, bus.out_valid}, 32'h0);
    enable = 1'b1;
    wait_drained("resume_timeout", 40);
    check("resume_count", {16'h0, word_count}, 32'd24);
    check("resume_seq_error", {31'h0, seq_error}, 32'h0);

    // Reset mid-operation with occ=2
    bus.out_ready = 1'b0;
    load(16'h0040, 2);
    repeat (6) @(negedge clk);
    check("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("mid_rst_busy",  {31'h0, busy},          32'h0);
    check("mid_rst_count", {16'h0, word_count},    32'h0);
    @(negedge clk);
    check("mid_rst_data",  {16'h0, bus.out_data},   32'h0);
    check("mid_rst_rd_en", {31'h0, bus.fifo_rd_en}, 32'h0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset, then sequence 0x0005, 0x0006, 0x0008
    load(16'h0005, 2);
    load(16'h0008, 1);
    repeat (10) begin
      @(negedge clk);
      if (bus.fifo_rd_en) idle_viol++;
    end
    check("post_rst_idle_busy", {31'h0, busy}, 32'h0);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.out_valid && bus.out_data == 16'h0008) && k < 30);
    check("seq_accept_timeout", {31'h0, (k < 30)}, 32'h1);
    check("seq_err_before",     {31'h0, seq_error}, 32'h0);
    @(negedge clk);
    check("seq_err_after",      {31'h0, seq_error}, {31'h0, EXP_SEQ_ERR});
    repeat (4) @(negedge clk);
    check("seq_err_sticky",     {31'h0, seq_error}, {31'h0, EXP_SEQ_ERR});
    check("seq_count",          {16'h0, word_count}, 32'd3);
    check("seq_sb_empty",       sb.size(), 32'd0);

    check("empty_read_violations", empty_viol, 32'd0);
    check("hold_violations",       hold_viol,  32'd0);
    check("idle_read_violations",  idle_viol,  32'd0);
    check("rate_violations",       rate_viol,  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
